// File: rtl/hazard_if.sv
// hazard_if: hazard controller bundle; slave = controller (pipeline inputs in, stall/flush/pc_sel/counters out), master = pipeline side
interface hazard_if #(parameter int CNT_W = 16);
  logic [31:0] ir_ID;
  logic memread_EX;
  logic [4:0] rd_EX;
  logic mdu_start_EX;
  logic mdu_done;
  logic taken_MEM;
  logic BP_ID;
  logic [1:0] pc_sel;
  logic stall;
  logic stall_EX;
  logic flush_IFID;
  logic flush_IDEX;
  logic flush_EXMEM;
  logic mdu_kill;
  logic [1:0] busy_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output ir_ID, memread_EX, rd_EX, mdu_start_EX, mdu_done, taken_MEM, BP_ID,
    input pc_sel, stall, stall_EX, flush_IFID, flush_IDEX, flush_EXMEM, mdu_kill, busy_state,
          stall_cnt, flush_cnt
  );
  modport slave (
    input ir_ID, memread_EX, rd_EX, mdu_start_EX, mdu_done, taken_MEM, BP_ID,
    output pc_sel, stall, stall_EX, flush_IFID, flush_IDEX, flush_EXMEM, mdu_kill, busy_state,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32 5-stage hazard/flush FSM; clk, rst (sync, active-high), h (hazard_if.slave: ir/load/MDU/branch in; pc_sel, stalls, flushes, mdu_kill, busy_state, saturating counters out)
module hazard_ctrl #(
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  hazard_if.slave h
);
  typedef enum logic [1:0] {IDLE = 2'd0, LU_STALL = 2'd1, MDU_WAIT = 2'd2} state_t;
  localparam logic [2:0] LU_INIT = 3'(LOAD_STALL_CYC - 1);
  state_t state_q, state_d;
  logic [2:0] lu_q, lu_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [6:0] opc;
  logic use_rs1, use_rs2, lu_haz, mdu_wait;
  logic rd_o, md_o, lu_o, bp_o;
  logic unused_ir;
  assign unused_ir = ^{h.ir_ID[31:25], h.ir_ID[14:7]};
  assign opc = h.ir_ID[6:0];
  assign use_rs1 = !(opc inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign use_rs2 = opc inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign lu_haz = h.memread_EX && h.rd_EX != 5'd0 &&
                  ((use_rs1 && h.rd_EX == h.ir_ID[19:15]) || (use_rs2 && h.rd_EX == h.ir_ID[24:20]));
  // start with done in the same cycle is a single-cycle op and never waits
  assign mdu_wait = h.mdu_start_EX && !h.mdu_done;
  assign stall_cnt_d = (h.stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (h.taken_MEM && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lu_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lu_q <= lu_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    lu_d = lu_q;
    if (h.taken_MEM) begin
      state_d = IDLE;
      lu_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu_wait) state_d = MDU_WAIT;
          else if (lu_haz && LOAD_STALL_CYC > 1) begin
            state_d = LU_STALL;
            lu_d = LU_INIT;
          end
        end
        LU_STALL: begin
          lu_d = lu_q - 3'd1;
          state_d = lu_q == 3'd1 ? IDLE : LU_STALL;
        end
        MDU_WAIT: state_d = h.mdu_done ? IDLE : MDU_WAIT;
        default: state_d = IDLE;
      endcase
    end
  end
  // one decision per cycle: redirect > MDU > load-use > BP > sequential
  always_comb begin
    rd_o = !rst && h.taken_MEM;
    md_o = !rst && !h.taken_MEM &&
           ((state_q == IDLE && mdu_wait) || (state_q == MDU_WAIT && !h.mdu_done));
    lu_o = !rst && !h.taken_MEM &&
           ((state_q == IDLE && !mdu_wait && lu_haz) || state_q == LU_STALL);
    bp_o = !rst && !h.taken_MEM && state_q == IDLE && !mdu_wait && !lu_haz && h.BP_ID;
    h.pc_sel = rd_o ? 2'b01 : (md_o || lu_o) ? 2'b11 : bp_o ? 2'b10 : 2'b00;
    h.stall = md_o || lu_o;
    h.stall_EX = md_o;
    h.flush_IFID = rd_o || bp_o;
    h.flush_IDEX = rd_o || lu_o;
    h.flush_EXMEM = rd_o || md_o;
    h.mdu_kill = rd_o && state_q == MDU_WAIT;
    h.busy_state = state_q;
    h.stall_cnt = stall_cnt_q;
    h.flush_cnt = flush_cnt_q;
  end
endmodule
